// File: rtl/idst4_seq_if.sv
// ---------------------------------------------------------------------------
// idst4_seq_if
// Handshake bundle between the coefficient dequantiser, the inverse 4-point
// DST engine and the residual buffer.
//   in_valid  : input beat valid                 (master -> slave)
//   in_ready  : engine can accept a beat         (slave  -> master)
//   in_coef   : signed coefficients Y[0..3]      (master -> slave)
//   out_valid : output beat valid                (slave  -> master)
//   out_ready : downstream accepts the beat      (master -> slave)
//   out_res   : signed reconstructed X[0..3]     (slave  -> master)
// The master modport is the side that feeds coefficients and drains results;
// the slave modport is the engine.
// ---------------------------------------------------------------------------
interface idst4_seq_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_coef [0:3];
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_res [0:3];

  modport master (
    output in_valid, in_coef, out_ready,
    input  in_ready, out_valid, out_res
  );

  modport slave (
    input  in_valid, in_coef, out_ready,
    output in_ready, out_valid, out_res
  );
endinterface

// File: rtl/idst4_seq.sv
// ---------------------------------------------------------------------------
// idst4_seq
// Inverse 4-point DST-VII (HEVC integer matrix). One 4-term MAC is reused
// over the four matrix columns; each column result is rounded, shifted
// right arithmetically and then narrowed to OUT_W.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : idst4_seq_if.slave (in_valid/in_ready/in_coef,
//           out_valid/out_ready/out_res)
//
// Build option:
//   IDST_SAT_EN defined   -> shifted result saturates to the OUT_W range.
//   IDST_SAT_EN undefined -> shifted result wraps to its low OUT_W bits.
//
// Flow: IDLE accepts a beat, CALC spends four cycles (one per output
// sample), OUT holds the block until downstream takes it. A new block is
// never accepted while OUT is held, so back-to-back blocks are 6 cycles apart.
// ---------------------------------------------------------------------------
module idst4_seq #(
  parameter int IN_W    = 16,
  parameter int COEFF_W = 8,
  parameter int ACC_W   = IN_W + COEFF_W + 2,
  parameter int SHIFT   = 7,
  parameter int OUT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  idst4_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] RND_C =
    {{(ACC_W-1){1'b0}}, 1'b1} << (SHIFT - 1);

`ifdef IDST_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [1:0]              idx_r;
  logic                    in_ready_r;
  logic                    out_valid_r;
  logic signed [IN_W-1:0]  coef_r    [0:3];
  logic signed [OUT_W-1:0] out_res_r [0:3];

  logic signed [ACC_W-1:0] acc_s;
  logic signed [ACC_W-1:0] rnd_s;
  logic signed [ACC_W-1:0] coef_ext_s;
  logic signed [ACC_W-1:0] mat_ext_s;
  logic signed [OUT_W-1:0] res_s;
`ifdef IDST_SAT_EN
  logic signed [ACC_W-1:0] sh_s;
`endif

  // DST-VII matrix entry M[k][i]; output i uses column i.
  function automatic logic signed [COEFF_W-1:0] dst_m(input logic [1:0] k,
                                                       input logic [1:0] i);
    logic signed [COEFF_W-1:0] m;
    case ({k, i})
      4'b00_00: m = 8'sd29;
      4'b00_01: m = 8'sd55;
      4'b00_10: m = 8'sd74;
      4'b00_11: m = 8'sd84;
      4'b01_00: m = 8'sd74;
      4'b01_01: m = 8'sd74;
      4'b01_10: m = 8'sd0;
      4'b01_11: m = -8'sd74;
      4'b10_00: m = 8'sd84;
      4'b10_01: m = -8'sd29;
      4'b10_10: m = -8'sd74;
      4'b10_11: m = 8'sd55;
      4'b11_00: m = 8'sd55;
      4'b11_01: m = -8'sd84;
      4'b11_10: m = 8'sd74;
      4'b11_11: m = -8'sd29;
      default:  m = 8'sd0;
    endcase
    return m;
  endfunction

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_r) state_nxt_s = ST_CALC;
        else                            state_nxt_s = ST_IDLE;
      end
      ST_CALC: begin
        if (idx_r == 2'd3) state_nxt_s = ST_OUT;
        else               state_nxt_s = ST_CALC;
      end
      ST_OUT: begin
        if (out_valid_r && bus.out_ready) state_nxt_s = ST_IDLE;
        else                              state_nxt_s = ST_OUT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Shared MAC over the current column plus the rounding offset.
  always_comb begin
    acc_s      = '0;
    coef_ext_s = '0;
    mat_ext_s  = '0;
    for (int k = 0; k < 4; k++) begin
      coef_ext_s = coef_r[k];
      mat_ext_s  = dst_m(2'(k), idx_r);
      acc_s      = acc_s + coef_ext_s * mat_ext_s;
    end
    rnd_s = acc_s + RND_C;
  end

`ifdef IDST_SAT_EN
  // Arithmetic shift (floor) then saturate to the OUT_W range.
  always_comb begin
    sh_s = rnd_s >>> SHIFT;
    if (sh_s > MAX_V)      res_s = MAX_V[OUT_W-1:0];
    else if (sh_s < MIN_V) res_s = MIN_V[OUT_W-1:0];
    else                   res_s = sh_s[OUT_W-1:0];
  end
`else
  // Arithmetic shift (floor) then keep the low OUT_W bits (two's-complement wrap).
  always_comb begin
    res_s = OUT_W'(rnd_s >>> SHIFT);
  end
`endif

  // State register with registered handshake outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_OUT);
    end
  end

  // Coefficient latch on the input handshake; column index restarts at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r <= 2'd0;
      for (int k = 0; k < 4; k++) coef_r[k] <= '0;
    end else if (state_r == ST_IDLE && bus.in_valid && in_ready_r) begin
      idx_r  <= 2'd0;
      coef_r <= bus.in_coef;
    end else if (state_r == ST_CALC) begin
      // Wraps back to 0 after column 3.
      idx_r <= idx_r + 2'd1;
    end
  end

  // Result store: one sample per CALC cycle, held in every other state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) out_res_r[k] <= '0;
    end else if (state_r == ST_CALC) begin
      out_res_r[idx_r] <= res_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_res   = out_res_r;

endmodule
